// File: rtl/rf_wrctl_if.sv
// Register-file write-control bus: writeback source, debug write handshake,
// and the registered RF write port with init status.
interface rf_wrctl_if;
    // Writeback unit (always accepted when enabled)
    logic        i_wbk_en;
    logic [4:0]  i_wbk_rdt;
    logic [31:0] i_wbk_data;
    // Debug write request with valid/ready handshake
    logic        i_dbg_wr_valid;
    logic [4:0]  i_dbg_wr_addr;
    logic [31:0] i_dbg_wr_data;
    logic        o_dbg_wr_ready;
    logic        o_dbg_starve;
    // Register-file write port
    logic        o_rf_wren;
    logic [4:0]  o_rf_wr_addr;
    logic [31:0] o_rf_wr_data;
    logic        o_init_done;

    // Side that drives the write sources and consumes the RF port
    modport master (
        output i_wbk_en, i_wbk_rdt, i_wbk_data,
        output i_dbg_wr_valid, i_dbg_wr_addr, i_dbg_wr_data,
        input  o_dbg_wr_ready, o_dbg_starve,
        input  o_rf_wren, o_rf_wr_addr, o_rf_wr_data, o_init_done
    );

    // Write controller side
    modport slave (
        input  i_wbk_en, i_wbk_rdt, i_wbk_data,
        input  i_dbg_wr_valid, i_dbg_wr_addr, i_dbg_wr_data,
        output o_dbg_wr_ready, o_dbg_starve,
        output o_rf_wren, o_rf_wr_addr, o_rf_wr_data, o_init_done
    );
endinterface

// File: rtl/rf_wrctl.sv
// Register-file write controller: clears x1..x31 after reset, then merges
// writeback (strict priority) and debug writes onto one registered RF port.
module rf_wrctl #(
    parameter bit          RF_CLR     = 1'b1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    rf_wrctl_if.slave  bus
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  clr_cnt, clr_cnt_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;

    logic        wren_nxt;
    logic [4:0]  addr_nxt;
    logic [31:0] data_nxt;

    logic        wren_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic        init_done_q;

    logic        dbg_ready;

    // Debug may only land in RUN when the writeback unit is idle.
    assign dbg_ready = (state == S_RUN) && !bus.i_wbk_en;

    // State register: FSM state, clear address counter and debug wait counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering inside the block does not matter.
        if (rst) begin
            state    <= S_INIT;
            clr_cnt  <= 5'd1;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state and next RF write selection.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        wait_cnt_nxt = 8'd0;
        wren_nxt     = 1'b0;
        addr_nxt     = addr_q;
        data_nxt     = data_q;

        case (state)
            S_INIT: begin
                if (RF_CLR) begin
                    wren_nxt    = 1'b1;
                    addr_nxt    = clr_cnt;
                    data_nxt    = 32'h0;
                    clr_cnt_nxt = clr_cnt + 5'd1;
                    if (clr_cnt == 5'd31) begin
                        state_nxt = S_RUN;
                    end
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.i_wbk_en) begin
                    // x0 is hardwired zero: drop the write, keep the port values.
                    if (bus.i_wbk_rdt != 5'd0) begin
                        wren_nxt = 1'b1;
                        addr_nxt = bus.i_wbk_rdt;
                        data_nxt = bus.i_wbk_data;
                    end
                    if (bus.i_dbg_wr_valid) begin
                        wait_cnt_nxt = (wait_cnt == STARVE_LIM) ? wait_cnt
                                                                : wait_cnt + 8'd1;
                    end
                end else if (bus.i_dbg_wr_valid) begin
                    // Accepted even for x0; only the RF write is suppressed.
                    if (bus.i_dbg_wr_addr != 5'd0) begin
                        wren_nxt = 1'b1;
                        addr_nxt = bus.i_dbg_wr_addr;
                        data_nxt = bus.i_dbg_wr_data;
                    end
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Registered RF write port and init-done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wren_q      <= 1'b0;
            addr_q      <= 5'd0;
            data_q      <= 32'h0;
            init_done_q <= 1'b0;
        end else begin
            wren_q      <= wren_nxt;
            addr_q      <= addr_nxt;
            data_q      <= data_nxt;
            init_done_q <= (state == S_RUN);
        end
    end

    assign bus.o_rf_wren      = wren_q;
    assign bus.o_rf_wr_addr   = addr_q;
    assign bus.o_rf_wr_data   = data_q;
    assign bus.o_init_done    = init_done_q;
    assign bus.o_dbg_wr_ready = dbg_ready;
    assign bus.o_dbg_starve   = (wait_cnt == STARVE_LIM);

endmodule

// File: tb/tb_rf_wrctl.sv
// Self-checking bench for rf_wrctl: expected RF writes are queued when the
// stimulus is driven and matched against the RF port as writes appear.
module tb_rf_wrctl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_wrctl_if bus ();

    rf_wrctl #(.RF_CLR(1'b1), .STARVE_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  wr_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_clear();
        for (int a = 1; a <= 31; a++) push(5'(a), 32'h0);
    endtask

    // Scoreboard monitor: every RF write must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.o_rf_wren === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(bus.o_rf_wr_addr), 32'(e.addr));
                check("wr_data", bus.o_rf_wr_data, e.data);
            end
        end
    end

    initial begin
        logic [31:0] d;

        rst                = 1'b1;
        bus.i_wbk_en       = 1'b0;
        bus.i_wbk_rdt      = 5'd0;
        bus.i_wbk_data     = 32'h0;
        bus.i_dbg_wr_valid = 1'b0;
        bus.i_dbg_wr_addr  = 5'd0;
        bus.i_dbg_wr_data  = 32'h0;

        // Reset state
        repeat (3) cyc();
        #2;
        check("rst_wren", 32'(bus.o_rf_wren), 32'd0);
        check("rst_addr", 32'(bus.o_rf_wr_addr), 32'd0);
        check("rst_data", bus.o_rf_wr_data, 32'h0);
        check("rst_init_done", 32'(bus.o_init_done), 32'd0);
        check("rst_ready", 32'(bus.o_dbg_wr_ready), 32'd0);
        check("rst_starve", 32'(bus.o_dbg_starve), 32'd0);

        // Clear sequence with both sources active and ignored
        cyc();
        wr_count = 0;
        push_clear();
        rst = 1'b0;
        for (int k = 0; k < 31; k++) begin
            bus.i_wbk_en       = 1'b1;
            bus.i_wbk_rdt      = 5'd9;
            bus.i_wbk_data     = $urandom;
            bus.i_dbg_wr_valid = 1'b1;
            bus.i_dbg_wr_addr  = 5'd4;
            bus.i_dbg_wr_data  = 32'hCAFE0000;
            #2;
            check("init_ready", 32'(bus.o_dbg_wr_ready), 32'd0);
            check("init_done_low", 32'(bus.o_init_done), 32'd0);
            check("init_starve", 32'(bus.o_dbg_starve), 32'd0);
            cyc();
        end
        bus.i_wbk_en       = 1'b0;
        bus.i_dbg_wr_valid = 1'b0;
        #2;
        check("init_done_last_clr", 32'(bus.o_init_done), 32'd0);
        cyc();
        check("clear_writes", 32'(wr_count), 32'd31);
        check("init_done_high", 32'(bus.o_init_done), 32'd1);

        // Writeback to x5, then to x0 (suppressed, port holds)
        bus.i_wbk_en   = 1'b1;
        bus.i_wbk_rdt  = 5'd5;
        bus.i_wbk_data = 32'hDEADBEEF;
        push(5'd5, 32'hDEADBEEF);
        cyc();
        bus.i_wbk_rdt  = 5'd0;
        bus.i_wbk_data = 32'h11111111;
        cyc();
        #2;
        check("x0_wren", 32'(bus.o_rf_wren), 32'd0);
        check("hold_addr", 32'(bus.o_rf_wr_addr), 32'd5);
        check("hold_data", bus.o_rf_wr_data, 32'hDEADBEEF);
        bus.i_wbk_en = 1'b0;
        cyc();
        check("idle_wren", 32'(bus.o_rf_wren), 32'd0);

        // Debug blocked by writeback for 3 cycles, accepted on the 4th
        bus.i_dbg_wr_valid = 1'b1;
        bus.i_dbg_wr_addr  = 5'd7;
        bus.i_dbg_wr_data  = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            bus.i_wbk_en   = 1'b1;
            bus.i_wbk_rdt  = 5'(10 + i);
            bus.i_wbk_data = d;
            push(5'(10 + i), d);
            #2;
            check("blocked_ready", 32'(bus.o_dbg_wr_ready), 32'd0);
            cyc();
        end
        bus.i_wbk_en = 1'b0;
        push(5'd7, 32'h12345678);
        #2;
        check("accept_ready", 32'(bus.o_dbg_wr_ready), 32'd1);
        cyc();
        bus.i_dbg_wr_valid = 1'b0;
        cyc();

        // Starvation flag after 8 waiting cycles, drops after acceptance
        bus.i_dbg_wr_valid = 1'b1;
        bus.i_dbg_wr_addr  = 5'd9;
        bus.i_dbg_wr_data  = 32'hA5A5A5A5;
        for (int i = 1; i <= 10; i++) begin
            d = $urandom;
            bus.i_wbk_en   = 1'b1;
            bus.i_wbk_rdt  = 5'(i);
            bus.i_wbk_data = d;
            push(5'(i), d);
            #2;
            check($sformatf("starve_c%0d", i), 32'(bus.o_dbg_starve), (i >= 9) ? 32'd1 : 32'd0);
            cyc();
        end
        bus.i_wbk_en = 1'b0;
        push(5'd9, 32'hA5A5A5A5);
        #2;
        check("starve_accept_ready", 32'(bus.o_dbg_wr_ready), 32'd1);
        cyc();
        bus.i_dbg_wr_valid = 1'b0;
        #2;
        check("starve_cleared", 32'(bus.o_dbg_starve), 32'd0);
        cyc();

        // Debug write to x0: handshake completes, no RF write
        bus.i_dbg_wr_valid = 1'b1;
        bus.i_dbg_wr_addr  = 5'd0;
        bus.i_dbg_wr_data  = 32'h77777777;
        #2;
        check("dbg_x0_ready", 32'(bus.o_dbg_wr_ready), 32'd1);
        cyc();
        bus.i_dbg_wr_valid = 1'b0;
        #2;
        check("dbg_x0_wren", 32'(bus.o_rf_wren), 32'd0);
        cyc();

        // Withdrawn request clears the wait counter
        bus.i_dbg_wr_valid = 1'b1;
        bus.i_dbg_wr_addr  = 5'd3;
        bus.i_dbg_wr_data  = 32'h33333333;
        for (int i = 1; i <= 9; i++) begin
            bus.i_wbk_en   = 1'b1;
            bus.i_wbk_rdt  = 5'd20;
            bus.i_wbk_data = 32'(i);
            push(5'd20, 32'(i));
            cyc();
        end
        bus.i_dbg_wr_valid = 1'b0;
        bus.i_wbk_en       = 1'b0;
        #2;
        check("withdraw_starve_held", 32'(bus.o_dbg_starve), 32'd1);
        cyc();
        bus.i_dbg_wr_valid = 1'b1;
        bus.i_wbk_en       = 1'b1;
        bus.i_wbk_rdt      = 5'd21;
        bus.i_wbk_data     = 32'h21;
        push(5'd21, 32'h21);
        #2;
        check("withdraw_starve_clr", 32'(bus.o_dbg_starve), 32'd0);
        cyc();
        bus.i_wbk_en       = 1'b0;
        bus.i_dbg_wr_valid = 1'b0;
        cyc();
        cyc();
        check("sb_drained_run", 32'(sb.size()), 32'd0);

        // Reset mid-RUN, then reset again at clear address 12
        rst = 1'b1;
        cyc();
        check("rerst_init_done", 32'(bus.o_init_done), 32'd0);
        wr_count = 0;
        push_clear();
        rst = 1'b0;
        bus.i_dbg_wr_valid = 1'b1;
        bus.i_dbg_wr_addr  = 5'd6;
        bus.i_dbg_wr_data  = 32'h66666666;
        for (int k = 0; k < 12; k++) begin
            #2;
            check("init1_ready", 32'(bus.o_dbg_wr_ready), 32'd0);
            cyc();
        end
        rst = 1'b1;
        cyc();
        check("partial_writes", 32'(wr_count), 32'd12);
        check("midrst_wren", 32'(bus.o_rf_wren), 32'd0);
        check("midrst_addr", 32'(bus.o_rf_wr_addr), 32'd0);
        check("midrst_init_done", 32'(bus.o_init_done), 32'd0);
        sb.delete();
        wr_count = 0;
        push_clear();
        rst = 1'b0;
        for (int k = 0; k < 31; k++) begin
            #2;
            check("init2_ready", 32'(bus.o_dbg_wr_ready), 32'd0);
            cyc();
        end
        bus.i_dbg_wr_valid = 1'b0;
        cyc();
        check("restart_writes", 32'(wr_count), 32'd31);
        check("restart_init_done", 32'(bus.o_init_done), 32'd1);
        cyc();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
